// File: rtl/dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp_pkg
//  Description : Shared size codes and lane helpers for the data-memory
//                responder (byte enables, store lane replication, load
//                extraction/extension).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_resp_pkg;

    localparam int          c_WORD_W    = 32;

    // Access size codes carried on req_size_i
    localparam logic [1:0]  c_DSIZE_B   = 2'b00;
    localparam logic [1:0]  c_DSIZE_H   = 2'b01;
    localparam logic [1:0]  c_DSIZE_W   = 2'b10;
    localparam logic [1:0]  c_DSIZE_BAD = 2'b11;

    // Byte-lane write enables for a store of the given size at byte offset off
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            c_DSIZE_B: be = 4'b0001 << off;
            c_DSIZE_H: be = 4'b0011 << off;
            c_DSIZE_W: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Alignment violation: halves need even offsets, words need offset 0
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            c_DSIZE_H: bad = off[0];
            c_DSIZE_W: bad = |off;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Replicate right-aligned store data across all lanes so any enabled
    // lane sees the correct byte regardless of offset
    function automatic logic [c_WORD_W-1:0] lane_data(input logic [1:0] size,
                                                      input logic [c_WORD_W-1:0] wdata);
        logic [c_WORD_W-1:0] d;
        d = wdata;
        case (size)
            c_DSIZE_B: d = {4{wdata[7:0]}};
            c_DSIZE_H: d = {2{wdata[15:0]}};
            default:   d = wdata;
        endcase
        return d;
    endfunction

    // Pull the addressed byte/half out of a read word and extend to 32 bits
    function automatic logic [c_WORD_W-1:0] load_extract(input logic [c_WORD_W-1:0] word,
                                                         input logic [1:0]          off,
                                                         input logic [1:0]          size,
                                                         input logic                uns);
        logic [c_WORD_W-1:0] sh;
        logic [c_WORD_W-1:0] res;
        sh  = word >> {off, 3'b000};
        res = sh;
        case (size)
            c_DSIZE_B: res = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            c_DSIZE_H: res = uns ? {16'h0000,   sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   res = word;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp_bank
//  Description : DEPTH x 32 synchronous single-port SRAM with per-byte write
//                enables and a registered read port that holds its value
//                whenever the read enable is low. Storage is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp_bank #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_re,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane writes; lanes with a clear enable keep their old contents
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we[l]) begin
                r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
    end

    // Registered read; output is held while no new read is requested
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp
//  Description : Data-memory responder. Accepts one load/store per cycle on a
//                valid/ready handshake, checks alignment/size/range, steers
//                store lanes into a byte-enabled bank and returns one in-order
//                response per request from a single response slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [1:0]         w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_high_oor;
    logic               w_idx_oor;
    logic               w_err;
    logic               w_accept;
    logic               w_rd_en;
    logic [3:0]         w_we;
    logic [31:0]        w_wdata;
    logic [31:0]        w_bank_rdata;

    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic               r_rsp_load;
    logic [1:0]         r_rsp_off;
    logic [1:0]         r_rsp_size;
    logic               r_rsp_uns;

    assign w_off = req_addr_i[1:0];
    assign w_idx = req_addr_i[2 +: c_IDX_W];

    // Any address bit above the word index makes the access out of range
    generate
        if (ADDR_W > 2 + c_IDX_W) begin : g_high_chk
            assign w_high_oor = |req_addr_i[ADDR_W-1:2+c_IDX_W];
        end else begin : g_no_high_chk
            assign w_high_oor = 1'b0;
        end
    endgenerate

    // Non-power-of-two depths leave unused index codes at the top
    generate
        if (DEPTH != (2 ** c_IDX_W)) begin : g_depth_chk
            localparam logic [c_IDX_W:0] c_DEPTH_V = (c_IDX_W + 1)'(DEPTH);
            assign w_idx_oor = ({1'b0, w_idx} >= c_DEPTH_V);
        end else begin : g_no_depth_chk
            assign w_idx_oor = 1'b0;
        end
    endgenerate

    assign w_err = misaligned(req_size_i, w_off) | (req_size_i == c_DSIZE_BAD) |
                   w_high_oor | w_idx_oor;

    // One response slot: a new request fits if the slot is empty or retiring now
    assign req_ready_o = !r_rsp_valid | rsp_ready_i;
    assign w_accept    = req_valid_i & req_ready_o;

    // Reset wins over an accept on the same edge, so gate array access with rst
    assign w_rd_en = w_accept & !req_we_i & !w_err & !rst;
    assign w_we    = (w_accept & req_we_i & !w_err & !rst) ? byte_en(req_size_i, w_off) : 4'b0000;
    assign w_wdata = lane_data(req_size_i, req_wdata_i);

    dmem_resp_bank #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_bank (
        .clk     (clk),
        .i_re    (w_rd_en),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Response slot: load on accept, clear on consume, accept wins when both happen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
            r_rsp_off   <= 2'b00;
            r_rsp_size  <= 2'b00;
            r_rsp_uns   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_load  <= !req_we_i & !w_err;
            r_rsp_off   <= w_off;
            r_rsp_size  <= req_size_i;
            r_rsp_uns   <= req_unsigned_i;
        end else if (r_rsp_valid & rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end
    end

    // Load data is formed from the held bank output; stores and errors return zero
    always_comb begin
        rsp_data_o = '0;
        if (r_rsp_valid & r_rsp_load) begin
            rsp_data_o = load_extract(w_bank_rdata, r_rsp_off, r_rsp_size, r_rsp_uns);
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_resp
//  Description : Self-checking bench for dmem_resp. A byte-addressed memory
//                model and an expected-response queue predict every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem [int unsigned];
    int          vec  = 0;
    int          mis  = 0;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    dmem_resp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_err_o      (rsp_err_o)
    );

    // Reference: byte-addressed memory, result computed from access rules
    function automatic exp_t model(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                   input bit uns, input logic [31:0] wdata);
        exp_t        e;
        int          n;
        int unsigned a;
        logic [31:0] val;
        e.data = 32'h0;
        e.err  = 1'b0;
        a      = addr;
        n      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (size == 2'd3 || (a % n) != 0 || a >= 4 * DEPTH) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < n; i++) mem[a + i] = wdata[8*i +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val[8*i +: 8] = mem[a + i];
            if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            e.data = val;
        end
        return e;
    endfunction

    // One cycle: check outputs against the queue, advance the model, move to next negedge
    task automatic tick(output bit acc);
        bit model_ready;
        #1;
        model_ready = (q.size() == 0) || rsp_ready_i;
        if (q.size() != 0) begin
            vec++;
            assert (rsp_valid_o === 1'b1) else begin
                mis++; $error("FAIL rsp_valid got %b want 1", rsp_valid_o);
            end
            vec++;
            assert (rsp_data_o === q[0].data) else begin
                mis++; $error("FAIL rsp_data got %h want %h", rsp_data_o, q[0].data);
            end
            vec++;
            assert (rsp_err_o === q[0].err) else begin
                mis++; $error("FAIL rsp_err got %b want %b", rsp_err_o, q[0].err);
            end
        end else begin
            vec++;
            assert (rsp_valid_o === 1'b0) else begin
                mis++; $error("FAIL rsp_valid_idle got %b want 0", rsp_valid_o);
            end
        end
        vec++;
        assert (req_ready_o === model_ready) else begin
            mis++; $error("FAIL req_ready got %b want %b", req_ready_o, model_ready);
        end
        acc = req_valid_i && model_ready && !rst;
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() != 0 && rsp_ready_i) void'(q.pop_front());
            if (acc) q.push_back(model(req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i));
        end
        @(negedge clk);
    endtask

    task automatic send(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata);
        bit acc;
        int n;
        n              = 0;
        acc            = 1'b0;
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        while (!acc && n < 64) begin
            if (rand_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
            tick(acc);
            n++;
        end
        vec++;
        assert (acc) else begin
            mis++; $error("FAIL send_timeout addr %h got no accept want accept", addr);
        end
        req_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        req_valid_i = 1'b0;
        repeat (n) tick(acc);
    endtask

    initial begin : main
        bit          acc;
        logic [31:0] a;
        int          r;

        rst            = 1'b1;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_addr_i     = '0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        req_wdata_i    = '0;
        rsp_ready_i    = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        vec++; assert (rsp_valid_o === 1'b0) else begin mis++; $error("FAIL reset_valid got %b want 0", rsp_valid_o); end
        vec++; assert (rsp_data_o === 32'h0) else begin mis++; $error("FAIL reset_data got %h want 0", rsp_data_o); end
        vec++; assert (rsp_err_o === 1'b0) else begin mis++; $error("FAIL reset_err got %b want 0", rsp_err_o); end
        vec++; assert (req_ready_o === 1'b1) else begin mis++; $error("FAIL reset_ready got %b want 1", req_ready_o); end
        rst = 1'b0;

        // Fill the working region so every later load has known contents
        for (int i = 0; i < 256; i += 4) send(1'b1, 32'(i), 2'd2, 1'b0, $urandom);

        // Word store/load
        send(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        send(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        // Byte store, signed/unsigned byte loads, merged word
        send(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080);
        send(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
        send(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        send(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        // Error cases, then memory at 0x10 unchanged
        send(1'b0, 32'h11, 2'd1, 1'b0, 32'h0);
        send(1'b1, 32'h12, 2'd2, 1'b0, 32'h5555_5555);
        send(1'b0, 32'(4 * DEPTH), 2'd2, 1'b0, 32'h0);
        send(1'b0, 32'h14, 2'd3, 1'b0, 32'h0);
        send(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        // Half-word store/loads at the upper half
        send(1'b1, 32'h32, 2'd1, 1'b0, 32'hABCD_8001);
        send(1'b0, 32'h32, 2'd1, 1'b0, 32'h0);
        send(1'b0, 32'h32, 2'd1, 1'b1, 32'h0);

        // Back-to-back loads with the consumer always ready
        for (int i = 0; i < 8; i++) send(1'b0, 32'(4 * i), 2'd2, 1'b0, 32'h0);
        // Stall: last response must stay put and the request side must close
        rsp_ready_i = 1'b0;
        idle(3);

        // Store presented during the stall is only taken once the slot frees
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h20;
        req_size_i = 2'd2; req_unsigned_i = 1'b0; req_wdata_i = 32'h1234_5678;
        tick(acc);
        tick(acc);
        rsp_ready_i = 1'b1;
        send(1'b1, 32'h20, 2'd2, 1'b0, 32'h1234_5678);
        send(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);

        // Reset with a response pending and a store on the reset edge
        send(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        rsp_ready_i = 1'b0;
        idle(1);
        rst = 1'b1; rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10;
        req_size_i = 2'd2; req_wdata_i = 32'hA5A5_A5A5;
        tick(acc);
        rst = 1'b0; req_valid_i = 1'b0;
        #1;
        vec++; assert (rsp_valid_o === 1'b0) else begin mis++; $error("FAIL post_reset_valid got %b want 0", rsp_valid_o); end
        vec++; assert (req_ready_o === 1'b1) else begin mis++; $error("FAIL post_reset_ready got %b want 1", req_ready_o); end
        @(negedge clk);
        send(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

        // Randomized traffic with random consumer back-pressure
        rand_ready = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) begin
                rsp_ready_i = ($urandom_range(0, 1) != 0);
                idle($urandom_range(1, 2));
            end
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else if (r == 1) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else             a = 32'($urandom_range(0, 255));
            send($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom);
        end
        rand_ready  = 1'b0;
        rsp_ready_i = 1'b1;
        idle(3);
        vec++;
        assert (q.size() == 0) else begin
            mis++; $error("FAIL drain got %0d pending want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
`default_nettype wire
